seq_extender: RTL and testbench
===============================

# seq_extender

Sequential immediate extender and rotator for the multicycle ARM datapath. It widens the legacy 2-bit-mode extender to a 3-bit mode set and adds three new modes: the ARM data-processing rotated immediate, the unsigned load/store offset, and the word-scaled branch offset. The rotation runs iteratively over several cycles behind a Start/Ready/Valid handshake, so the control FSM can overlap it with register fetch. The block sits between the instruction register and the ALU SrcB mux and drives the shifter carry.

## Interface
- WIDTH, 32: output width; legal range 26..64.
- STEP, 2: bits rotated per cycle; legal values 1 or 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRESET  in  1  synchronous, active-low reset.
- Start  in  1  request; accepted when Ready=1.
- Mode  in  3  extension mode, sampled on accept.
- Number  in  24  instruction field Instr[23:0], sampled on accept.
- CarryIn  in  1  current CPSR C flag, sampled on accept.
- Ready  out  1  high in IDLE and DONE states.
- Valid  out  1  one-cycle pulse; Extended and CarryOut are final while it is high.
- Extended  out  WIDTH  result; held from Valid until the next accept.
- CarryOut  out  1  shifter carry for the rotated immediate.

## Operation
- Modes:
  - 000: sign-extend Number[7:0].
  - 001: sign-extend Number[11:0].
  - 010: sign-extend Number[23:0].
  - 011: zero.
  - 100: zero-extend Number[7:0], then rotate right by 2*Number[11:8].
  - 101: zero-extend Number[11:0].
  - 110: sign-extend Number[23:0], then shift left 2.
  - 111: zero.
- All extensions are to WIDTH bits. The rotation is a WIDTH-bit rotate; bits wrap from bit 0 to bit WIDTH-1.
- CarryOut:
  - Mode 100 with rot≠0: CarryOut = Extended[WIDTH-1] after rotation.
  - All other cases: CarryOut = latched CarryIn.
- FSM states IDLE, ROTATE, DONE. Transitions:
  - IDLE or DONE, Start=1: latch the extended (unrotated) value into the result register and load the counter with 2*rot/STEP (0 for non-rotating modes). Go to DONE if the counter is 0, otherwise to ROTATE.
  - IDLE or DONE, Start=0: go to IDLE.
  - ROTATE: each cycle rotate the register right by STEP and decrement the counter. Go to DONE on the cycle the counter reaches 0.
- Valid = (state==DONE).
- Start while in ROTATE is ignored: no latch, no queueing. The requester must hold or reissue it.
- The result register is not updated outside accept and ROTATE, so Extended stays stable after Valid.

## Timing
- Reset: a sampled nRESET=0 forces the following values. This applies even mid-rotation; the operation is aborted and no Valid is issued.
  - state = IDLE
  - Extended = 0
  - CarryOut = 0
  - Valid = 0
  - Ready = 1
- Accept on edge n:
  - Non-rotating or rot=0: Valid is high in cycle n+1 (latency 1).
  - Mode 100 with rot≠0: Valid is high in cycle n+1+2*rot/STEP.
  - STEP=2, rot=15: latency 16.
  - STEP=1, rot=15: latency 31.
- Back-to-back: Start high during the DONE cycle is accepted. Non-rotating requests therefore sustain one result per cycle, with Valid high continuously.
- Ready and Valid are decoded from registered state only; there is no combinational path from the inputs to the outputs.
- Simultaneous reset and Start: reset wins and the request is dropped.

## Configuration
- `SEQ_EXTENDER_FAST_ROT_EN` defined:
  - A combinational barrel rotator is used.
  - ROTATE is never entered; every mode has latency 1.
  - Ready is constant 1 after reset.
  - STEP is ignored.
- Undefined: iterative rotation as described above (default; smaller area).
- Results and CarryOut are bit-identical in both builds; only latency differs.

## Test plan
- Mode 000, Number=0x000080, WIDTH=32 -> Valid at n+1, Extended=0xFFFFFF80, CarryOut=CarryIn.
- Mode 100, Number=0x0004FF (rot=4), STEP=2 -> Ready low for cycles n+1..n+4, Valid at n+5, Extended=0xFF000000, CarryOut=1. With the macro defined: Valid at n+1, same values.
- Mode 100, Number=0x000081 (rot=0), CarryIn=0 -> Valid at n+1, Extended=0x00000081, CarryOut=0. Repeat with CarryIn=1 -> CarryOut=1.
- Mode 110, Number=0xFFFFFE -> Extended=0xFFFFFFF8. Mode 101, Number=0x000FFF -> Extended=0x00000FFF.
- Start with mode 000 pulsed during ROTATE of a rot=8 request -> ignored; the first result is unchanged and only one Valid pulse is issued.
- nRESET=0 for one cycle during ROTATE -> next cycle Extended=0, Valid=0, Ready=1, no Valid ever. A new request then completes normally.

Source files
------------

// File: rtl/seq_extender.sv
// seq_extender: ARM immediate extender/rotator (modes 000..111) feeding ALU SrcB and shifter carry.
// Latency: accept->Valid 1 cycle; mode 100 with rot!=0 adds 2*rot/STEP cycles (SEQ_EXTENDER_FAST_ROT_EN: always 1).
// Backpressure: Ready low while rotating; Start is then ignored and must be held or reissued.
module seq_extender #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [23:0]      Number,
  input  logic             CarryIn,
  output logic             Ready,
  output logic             Valid,
  output logic [WIDTH-1:0] Extended,
  output logic             CarryOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cin_q, cin_d;
  // Set when the accepted request is a rotated immediate with a nonzero amount;
  // selects the shifter carry from the rotated result instead of the CPSR C flag.
  logic             rot_nz_q, rot_nz_d;
  logic [WIDTH-1:0] ext_val;
  logic [3:0]       rot;

  assign rot = Number[11:8];

  // Unrotated extension of the instruction field for the requested mode.
  always_comb begin
    ext_val = '0;
    case (Mode)
      3'b000:  ext_val = {{(WIDTH-8){Number[7]}}, Number[7:0]};
      3'b001:  ext_val = {{(WIDTH-12){Number[11]}}, Number[11:0]};
      3'b010:  ext_val = {{(WIDTH-24){Number[23]}}, Number};
      3'b100:  ext_val = {{(WIDTH-8){1'b0}}, Number[7:0]};
      3'b101:  ext_val = {{(WIDTH-12){1'b0}}, Number[11:0]};
      3'b110:  ext_val = {{(WIDTH-24){Number[23]}}, Number} << 2;
      default: ext_val = '0;
    endcase
  end

`ifdef SEQ_EXTENDER_FAST_ROT_EN

  // Rotate right by sh; a zero amount leaves v unchanged (the left shift by WIDTH yields 0).
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [4:0] sh);
    rotr = (v >> sh) | (v << (WIDTH - int'(sh)));
  endfunction

  // Next state: every request completes in one cycle through the barrel rotator.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    cin_d    = cin_q;
    rot_nz_d = rot_nz_q;
    if (Start) begin
      rot_nz_d = (Mode == 3'b100) && (rot != 4'd0);
      cin_d    = CarryIn;
      res_d    = rot_nz_d ? rotr(ext_val, {rot, 1'b0}) : ext_val;
      state_d  = DONE;
    end else begin
      state_d  = IDLE;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      res_q    <= '0;
      cin_q    <= 1'b0;
      rot_nz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      cin_q    <= cin_d;
      rot_nz_q <= rot_nz_d;
    end
  end

  assign Ready = 1'b1;

`else

  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       cnt_load;
  logic [WIDTH-1:0] rot_step;

  // Counter holds remaining STEP-sized rotations; a 2*rot amount splits into rot double-steps.
  assign cnt_load = (STEP == 1) ? {rot, 1'b0} : {1'b0, rot};
  assign rot_step = (res_q >> STEP) | (res_q << (WIDTH - STEP));

  // Next state: latch on accept, then rotate the result register STEP bits per cycle.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    cin_d    = cin_q;
    rot_nz_d = rot_nz_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          rot_nz_d = (Mode == 3'b100) && (rot != 4'd0);
          cin_d    = CarryIn;
          res_d    = ext_val;
          cnt_d    = rot_nz_d ? cnt_load : 5'd0;
          state_d  = rot_nz_d ? ROTATE : DONE;
        end else begin
          state_d  = IDLE;
        end
      end
      ROTATE: begin
        res_d = rot_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers with synchronous reset (aborts any rotation).
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      res_q    <= '0;
      cin_q    <= 1'b0;
      rot_nz_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      cin_q    <= cin_d;
      rot_nz_q <= rot_nz_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Ready = (state_q != ROTATE);

`endif

  assign Valid    = (state_q == DONE);
  assign Extended = res_q;
  assign CarryOut = rot_nz_q ? res_q[WIDTH-1] : cin_q;

endmodule

// File: tb/tb_seq_extender.sv
module tb_seq_extender;
  localparam int W    = 32;
  localparam int STEP = 2;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [23:0]   num = 24'd0;
  logic          cin = 1'b0;
  logic          ready, valid, carry_out;
  logic [W-1:0]  extended;
  logic [W-1:0]  last_ext = '0;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] ext;
    logic         carry;
    int           at;
  } exp_t;

  exp_t sb[$];

  seq_extender #(.WIDTH(W), .STEP(STEP)) dut (
    .CLK      (clk),
    .nRESET   (n_reset),
    .Start    (start),
    .Mode     (mode),
    .Number   (num),
    .CarryIn  (cin),
    .Ready    (ready),
    .Valid    (valid),
    .Extended (extended),
    .CarryOut (carry_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: extend, then rotate one bit at a time; now = cycle count at drive time.
  function automatic exp_t model(input logic [2:0] m, input logic [23:0] n, input logic c, input int now);
    exp_t         e;
    logic [W-1:0] v;
    int           r;
    r = 0;
    case (m)
      3'd0: v = W'($signed(n[7:0]));
      3'd1: v = W'($signed(n[11:0]));
      3'd2: v = W'($signed(n));
      3'd4: begin v = W'(n[7:0]); r = 2 * int'(n[11:8]); end
      3'd5: v = W'(n[11:0]);
      3'd6: v = W'($signed(n)) << 2;
      default: v = '0;
    endcase
    for (int i = 0; i < r; i++) v = {v[0], v[W-1:1]};
    e.ext   = v;
    e.carry = (r != 0) ? v[W-1] : c;
`ifdef SEQ_EXTENDER_FAST_ROT_EN
    e.at    = now + 1;
`else
    e.at    = now + 1 + r / STEP;
`endif
    return e;
  endfunction

  // Scoreboard: every Valid cycle must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("extended", 64'(extended), 64'(e.ext));
        check_eq("carry_out", 64'(carry_out), 64'(e.carry));
        check_eq("valid_cycle", 64'(cyc), 64'(e.at));
        last_ext = e.ext;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for Ready (bounded), drives one request and leaves Start high for the caller.
  task automatic issue(input logic [2:0] m, input logic [23:0] n, input logic c);
    int w = 0;
    while (ready !== 1'b1 && w < 64) begin
      start = 1'b0;
      tick();
      w++;
    end
    if (ready !== 1'b1) check_eq("ready_timeout", 64'(ready), 64'd1);
    mode  = m;
    num   = n;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(m, n, c, cyc));
    tick();
  endtask

  task automatic drain(input int budget);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    tick();
  endtask

  logic exp_busy_rdy;

  initial begin
`ifdef SEQ_EXTENDER_FAST_ROT_EN
    exp_busy_rdy = 1'b1;
`else
    exp_busy_rdy = 1'b0;
`endif
    // Reset state
    n_reset = 1'b0;
    tick();
    tick();
    check_eq("rst_extended", 64'(extended), 64'd0);
    check_eq("rst_carry", 64'(carry_out), 64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd1);
    n_reset = 1'b1;
    tick();

    // Directed cases
    issue(3'b000, 24'h000080, 1'b1);
    drain(10);
    issue(3'b100, 24'h0004FF, 1'b0);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_eq("ready_busy", 64'(ready), 64'(exp_busy_rdy));
      tick();
    end
    check_eq("ready_after_rot", 64'(ready), 64'd1);
    drain(10);
    issue(3'b100, 24'h000081, 1'b0);
    drain(10);
    issue(3'b100, 24'h000081, 1'b1);
    drain(10);
    issue(3'b110, 24'hFFFFFE, 1'b0);
    issue(3'b101, 24'h000FFF, 1'b1);
    drain(10);
    issue(3'b100, 24'h000F01, 1'b0);
    drain(40);

    // Back-to-back non-rotating requests: Valid every cycle
    issue(3'b001, 24'h000800, 1'b0);
    issue(3'b010, 24'h800000, 1'b1);
    issue(3'b011, 24'h123456, 1'b1);
    issue(3'b111, 24'hFFFFFF, 1'b0);
    issue(3'b100, 24'h0000FF, 1'b1);
    drain(10);
    for (int j = 0; j < 3; j++) tick();
    check_eq("result_hold", 64'(extended), 64'(last_ext));

    // Start during ROTATE is ignored
    issue(3'b100, 24'h0008F0, 1'b1);
    start = 1'b0;
    tick();
    mode  = 3'b000;
    num   = 24'h000080;
    start = 1'b1;
    if (ready === 1'b1) sb.push_back(model(3'b000, 24'h000080, 1'b1, cyc));
    tick();
    drain(40);
    for (int j = 0; j < 4; j++) tick();

    // Reset mid-rotation aborts with no Valid
    issue(3'b100, 24'h0008F0, 1'b1);
    start = 1'b0;
    tick();
    tick();
    n_reset = 1'b0;
    sb.delete();
    tick();
    n_reset = 1'b1;
    check_eq("abort_extended", 64'(extended), 64'd0);
    check_eq("abort_valid", 64'(valid), 64'd0);
    check_eq("abort_ready", 64'(ready), 64'd1);
    check_eq("abort_carry", 64'(carry_out), 64'd0);
    for (int j = 0; j < 12; j++) tick();
    issue(3'b100, 24'h000C3F, 1'b0);
    drain(40);

    // Reset and Start together: reset wins
    issue(3'b000, 24'h00007F, 1'b1);
    drain(10);
    n_reset = 1'b0;
    mode    = 3'b000;
    num     = 24'h000055;
    start   = 1'b1;
    tick();
    n_reset = 1'b0;
    start   = 1'b0;
    n_reset = 1'b1;
    check_eq("rst_start_extended", 64'(extended), 64'd0);
    check_eq("rst_start_ready", 64'(ready), 64'd1);
    tick();
    check_eq("rst_start_valid", 64'(valid), 64'd0);

    // Random mix with random gaps
    for (int k = 0; k < 40; k++) begin
      int gap;
      issue(3'($urandom_range(0, 7)), 24'($urandom), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        start = 1'b0;
        for (int j = 0; j < gap; j++) tick();
      end
    end
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
